// File: rtl/kf8237_channel_sequencer.sv
// KF8237 channel sequencer: DREQ arbitration, HRQ/HLDA handshake and the
// SI/S0..S4 transfer state machine that drives the address/count register block.
module kf8237_channel_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_clock_posedge,
    input  logic       cpu_clock_negedge,
    input  logic [3:0] dma_request,
    input  logic [3:0] channel_mask,
    input  logic       controller_disable,
    input  logic       rotating_priority_config,
    input  logic [7:0] transfer_mode,
    input  logic [3:0] autoinitialize_config,
    input  logic       underflow,
    input  logic       end_of_process_in,
    input  logic       clear_tc_status,
    input  logic       hold_acknowledge,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge,
    output logic [3:0] transfer_register_select,
    output logic       next_word,
    output logic       initialize_current_register,
    output logic       terminal_count,
    output logic [3:0] set_mask_on_tc,
    output logic [3:0] tc_status,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5
    } state_t;

    state_t     state_reg;
    logic [1:0] active_ch_reg;
    logic [1:0] priority_ptr_reg;
    logic       hold_request_reg;
    logic [3:0] dack_reg;
    logic [3:0] select_reg;
    logic       next_word_reg;
    logic       init_reg;
    logic       terminal_count_reg;
    logic [3:0] set_mask_reg;
    logic [3:0] tc_status_reg;
    logic       reload_tail_reg;     // select held one extra clock after a TC
    logic       hlda_lost_reg;       // HLDA dropped somewhere in S1..S4
    logic       word_committed_reg;  // register block has seen its S4 falling edge

    logic [3:0] eligible;
    logic [3:0] mode_block;
    logic [3:0] mode_demand;
    logic [3:0] active_onehot;
    logic [1:0] search_base;
    logic [1:0] search_idx;
    logic [1:0] winner;
    logic       tc_event;
    logic       keep_going;

    assign eligible = controller_disable ? 4'b0000 : (dma_request & ~channel_mask);

    // Per-channel mode decode; reserved mode 11 falls through as single
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_channel
            assign mode_block[gi]    = (transfer_mode[2*gi +: 2] == 2'b10);
            assign mode_demand[gi]   = (transfer_mode[2*gi +: 2] == 2'b00);
            assign active_onehot[gi] = (active_ch_reg == 2'(gi));
        end
    endgenerate

    // Priority search: nearest eligible channel at or after the search base
    always_comb begin
        search_base = rotating_priority_config ? priority_ptr_reg : 2'd0;
        search_idx  = search_base;
        winner      = search_base;
        for (int k = 3; k >= 0; k--) begin
            search_idx = search_base + 2'(k);
            if (eligible[search_idx]) begin
                winner = search_idx;
            end
        end
    end

    assign tc_event   = underflow | end_of_process_in;
    assign keep_going = mode_block[active_ch_reg] |
                        (mode_demand[active_ch_reg] & dma_request[active_ch_reg]);

    // Transfer state machine with registered handshake and strobe outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg          <= ST_SI;
            active_ch_reg      <= 2'd0;
            priority_ptr_reg   <= 2'd0;
            hold_request_reg   <= 1'b0;
            dack_reg           <= 4'b0000;
            select_reg         <= 4'b0000;
            next_word_reg      <= 1'b0;
            init_reg           <= 1'b0;
            terminal_count_reg <= 1'b0;
            set_mask_reg       <= 4'b0000;
            tc_status_reg      <= 4'b0000;
            reload_tail_reg    <= 1'b0;
            hlda_lost_reg      <= 1'b0;
            word_committed_reg <= 1'b0;
        end else begin
            terminal_count_reg <= 1'b0;
            init_reg           <= 1'b0;
            set_mask_reg       <= 4'b0000;
            tc_status_reg      <= clear_tc_status ? 4'b0000 : tc_status_reg;

            if (reload_tail_reg) begin
                select_reg      <= 4'b0000;
                reload_tail_reg <= 1'b0;
            end

            if ((state_reg inside {ST_S1, ST_S2, ST_S3, ST_S4}) && !hold_acknowledge) begin
                hlda_lost_reg <= 1'b1;
            end

            if (state_reg == ST_S4 && cpu_clock_negedge) begin
                word_committed_reg <= 1'b1;
            end

            if (cpu_clock_posedge) begin
                case (state_reg)
                    ST_SI: begin
                        if (!reload_tail_reg && eligible != 4'b0000) begin
                            active_ch_reg    <= winner;
                            hold_request_reg <= 1'b1;
                            select_reg       <= 4'b0001 << winner;
                            state_reg        <= ST_S0;
                        end
                    end
                    ST_S0: begin
                        if (hold_acknowledge) begin
                            dack_reg      <= active_onehot;
                            hlda_lost_reg <= 1'b0;
                            state_reg     <= ST_S1;
                        end else if (eligible == 4'b0000) begin
                            hold_request_reg <= 1'b0;
                            select_reg       <= 4'b0000;
                            state_reg        <= ST_SI;
                        end
                    end
                    ST_S1: state_reg <= ST_S2;
                    ST_S2: state_reg <= ST_S3;
                    ST_S3: begin
                        next_word_reg      <= 1'b1;
                        word_committed_reg <= 1'b0;
                        state_reg          <= ST_S4;
                    end
                    ST_S4: begin
                        // Leave S4 only once the register block has committed the word
                        if (word_committed_reg) begin
                            next_word_reg      <= 1'b0;
                            word_committed_reg <= 1'b0;
                            if (tc_event) begin
                                terminal_count_reg            <= 1'b1;
                                tc_status_reg[active_ch_reg]  <= 1'b1;
                                if (autoinitialize_config[active_ch_reg]) begin
                                    init_reg <= 1'b1;
                                end else begin
                                    set_mask_reg <= active_onehot;
                                end
                                reload_tail_reg  <= 1'b1;
                                hold_request_reg <= 1'b0;
                                dack_reg         <= 4'b0000;
                                hlda_lost_reg    <= 1'b0;
                                state_reg        <= ST_SI;
                                if (rotating_priority_config) begin
                                    priority_ptr_reg <= active_ch_reg + 2'd1;
                                end
                            end else if (keep_going && !hlda_lost_reg && hold_acknowledge) begin
                                state_reg <= ST_S1;
                            end else begin
                                hold_request_reg <= 1'b0;
                                dack_reg         <= 4'b0000;
                                select_reg       <= 4'b0000;
                                hlda_lost_reg    <= 1'b0;
                                state_reg        <= ST_SI;
                                if (rotating_priority_config) begin
                                    priority_ptr_reg <= active_ch_reg + 2'd1;
                                end
                            end
                        end
                    end
                    default: state_reg <= ST_SI;
                endcase
            end
        end
    end

    assign hold_request                = hold_request_reg;
    assign dma_acknowledge             = dack_reg;
    assign transfer_register_select    = select_reg;
    assign next_word                   = next_word_reg;
    assign initialize_current_register = init_reg;
    assign terminal_count              = terminal_count_reg;
    assign set_mask_on_tc              = set_mask_reg;
    assign tc_status                   = tc_status_reg;
    assign state                       = state_reg;

endmodule

// File: tb/tb_kf8237_channel_sequencer.sv
// Randomized bench for kf8237_channel_sequencer against a transaction-level model:
// who wins arbitration, how many words move, whether TC fires and what it leaves behind.
module tb_kf8237_channel_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_clock_posedge = 1'b0;
    logic       cpu_clock_negedge = 1'b0;
    logic [3:0] dma_request = 4'b0;
    logic [3:0] channel_mask = 4'b0;
    logic       controller_disable = 1'b0;
    logic       rotating_priority_config = 1'b0;
    logic [7:0] transfer_mode = 8'b0;
    logic [3:0] autoinitialize_config = 4'b0;
    logic       underflow = 1'b0;
    logic       end_of_process_in = 1'b0;
    logic       clear_tc_status = 1'b0;
    logic       hold_acknowledge = 1'b0;
    logic       hold_request;
    logic [3:0] dma_acknowledge;
    logic [3:0] transfer_register_select;
    logic       next_word;
    logic       initialize_current_register;
    logic       terminal_count;
    logic [3:0] set_mask_on_tc;
    logic [3:0] tc_status;
    logic [2:0] state;

    kf8237_channel_sequencer dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .cpu_clock_posedge           (cpu_clock_posedge),
        .cpu_clock_negedge           (cpu_clock_negedge),
        .dma_request                 (dma_request),
        .channel_mask                (channel_mask),
        .controller_disable          (controller_disable),
        .rotating_priority_config    (rotating_priority_config),
        .transfer_mode               (transfer_mode),
        .autoinitialize_config       (autoinitialize_config),
        .underflow                   (underflow),
        .end_of_process_in           (end_of_process_in),
        .clear_tc_status             (clear_tc_status),
        .hold_acknowledge            (hold_acknowledge),
        .hold_request                (hold_request),
        .dma_acknowledge             (dma_acknowledge),
        .transfer_register_select    (transfer_register_select),
        .next_word                   (next_word),
        .initialize_current_register (initialize_current_register),
        .terminal_count              (terminal_count),
        .set_mask_on_tc              (set_mask_on_tc),
        .tc_status                   (tc_status),
        .state                       (state)
    );

    initial forever #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_ptr = 0;
    logic [3:0] m_tcs = 4'b0;

    // Monitor accumulators
    int         nw_count, tc_cnt, init_cnt;
    logic [3:0] mask_acc, init_sel, dack_acc;
    logic       nw_prev;
    int         phase = 0;

    // Current transfer stimulus plan
    bit in_xfer = 0;
    int cur_ch = 0, cur_tc_word = 99, cur_drop_word = 99;
    bit use_eop = 0, clr_at_tc = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] elig, input int base);
        int order[$];
        for (int k = 0; k < 4; k++) order.push_back((base + k) % 4);
        foreach (order[i]) if (elig[order[i]]) return order[i];
        return 0;
    endfunction

    task automatic clear_mon();
        nw_count = 0; tc_cnt = 0; init_cnt = 0;
        mask_acc = 0; init_sel = 0; dack_acc = 0; nw_prev = 0;
    endtask

    // One system clock: sample outputs, then drive strobes and the per-word stimulus
    task automatic step();
        @(negedge clock);
        if (next_word && !nw_prev) nw_count++;
        nw_prev = next_word;
        if (terminal_count) tc_cnt++;
        mask_acc |= set_mask_on_tc;
        if (initialize_current_register) begin
            init_cnt++;
            init_sel |= transfer_register_select;
        end
        dack_acc |= dma_acknowledge;
        phase = (phase + 1) % 4;
        cpu_clock_posedge = (phase == 0);
        cpu_clock_negedge = (phase == 2);
        if (in_xfer && next_word) begin
            if (nw_count == cur_tc_word) begin
                if (use_eop) end_of_process_in = 1'b1; else underflow = 1'b1;
                clear_tc_status = (clr_at_tc && phase == 0);
            end else begin
                underflow = 1'b0; end_of_process_in = 1'b0; clear_tc_status = 1'b0;
            end
            if (nw_count == cur_drop_word) dma_request[cur_ch] = 1'b0;
        end else begin
            underflow = 1'b0; end_of_process_in = 1'b0; clear_tc_status = 1'b0;
        end
    endtask

    task automatic run_scenario(input int n);
        logic [3:0] elig, onehot;
        int w, mode, exp_words, t, hl_delay;
        bit rot, exp_tc, ai;
        dma_request = 0; hold_acknowledge = 0; in_xfer = 0;
        repeat (8) step();
        if ($urandom_range(0, 3) == 0) begin
            clear_tc_status = 1'b1;
            step();
            m_tcs = 4'b0;
        end
        rot = 1'($urandom_range(0, 1));
        rotating_priority_config = rot;
        transfer_mode = 8'($urandom);
        autoinitialize_config = 4'($urandom);
        elig = 4'($urandom_range(1, 15));
        channel_mask = 4'($urandom) & ~elig;
        w = pick_winner(elig, rot ? m_ptr : 0);
        onehot = 4'b0001 << w;
        ai = autoinitialize_config[w];
        mode = int'((transfer_mode >> (2 * w)) & 8'd3);
        cur_ch = w;
        use_eop = 1'($urandom_range(0, 1));
        clr_at_tc = ($urandom_range(0, 2) == 0);
        if (mode == 2) begin
            cur_tc_word = $urandom_range(1, 4); cur_drop_word = 99; exp_words = cur_tc_word;
        end else if (mode == 0) begin
            cur_tc_word = $urandom_range(1, 5); cur_drop_word = $urandom_range(1, 4);
            exp_words = (cur_tc_word < cur_drop_word) ? cur_tc_word : cur_drop_word;
        end else begin
            cur_tc_word = $urandom_range(1, 2); cur_drop_word = 99; exp_words = 1;
        end
        exp_tc = (cur_tc_word <= exp_words);
        clear_mon();
        in_xfer = 1;
        dma_request = elig | (4'($urandom) & channel_mask);

        t = 0;
        while (!hold_request && t < 40) begin step(); t++; end
        check_value("hrq_up", hold_request, 1);
        check_value("s0_state", state, 1);
        check_value("s0_select", transfer_register_select, onehot);
        hl_delay = $urandom_range(0, 3);
        repeat (4 * hl_delay) step();
        hold_acknowledge = 1'b1;
        t = 0;
        while (hold_request && t < 400) begin step(); t++; end
        check_value("hrq_down", hold_request, 0);
        hold_acknowledge = 1'b0;
        dma_request = 4'b0;
        in_xfer = 0;
        repeat (3) step();

        if (exp_tc) m_tcs = clr_at_tc ? onehot : (m_tcs | onehot);
        if (rot) m_ptr = (w + 1) % 4;

        check_value("served_ch", dack_acc, onehot);
        check_value("words", nw_count, exp_words);
        check_value("tc_pulses", tc_cnt, exp_tc ? 1 : 0);
        check_value("mask_pulse", mask_acc, (exp_tc && !ai) ? onehot : 4'b0);
        check_value("init_pulses", init_cnt, (exp_tc && ai) ? 1 : 0);
        check_value("init_select", init_sel, (exp_tc && ai) ? onehot : 4'b0);
        check_value("tc_status", tc_status, m_tcs);
        check_value("idle_select", transfer_register_select, 0);
        $display("scenario %0d: ch=%0d mode=%0d rot=%0d words=%0d tc=%0d tcs=%b", n, w, mode, rot, exp_words, exp_tc, m_tcs);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_hrq"}, hold_request, 0);
        check_value({tag, "_dack"}, dma_acknowledge, 0);
        check_value({tag, "_select"}, transfer_register_select, 0);
        check_value({tag, "_next_word"}, next_word, 0);
        check_value({tag, "_tc"}, terminal_count, 0);
        check_value({tag, "_tc_status"}, tc_status, 0);
        check_value({tag, "_state"}, state, 0);
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        repeat (6) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) step();
        $display("reset released");

        for (int n = 0; n < 40; n++) run_scenario(n);

        // Eligible set empties in S0: HRQ withdrawn with no acknowledge
        clear_mon();
        channel_mask = 4'b0;
        dma_request = 4'b0100;
        t = 0;
        while (!hold_request && t < 40) begin step(); t++; end
        check_value("abort_hrq_up", hold_request, 1);
        dma_request = 4'b0;
        t = 0;
        while (hold_request && t < 40) begin step(); t++; end
        check_value("abort_hrq_down", hold_request, 0);
        check_value("abort_dack", dack_acc, 0);
        check_value("abort_state", state, 0);
        $display("s0 abort done");

        // Reset asserted while in S3
        clear_mon();
        channel_mask = 4'b0;
        transfer_mode = 8'b0000_0010;
        dma_request = 4'b0001;
        hold_acknowledge = 1'b1;
        t = 0;
        while (state != 3'd4 && t < 100) begin step(); t++; end
        check_value("reach_s3", state, 4);
        reset_n = 1'b0;
        step();
        check_all_zero("midreset");
        reset_n = 1'b1;
        dma_request = 4'b0;
        hold_acknowledge = 1'b0;
        m_ptr = 0;
        m_tcs = 4'b0;
        $display("mid-transfer reset done");

        for (int n = 40; n < 60; n++) run_scenario(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
